sys_array_ctrl: RTL and testbench

Sequencing controller for the weight-stationary `sys_array` tile. It accepts one matrix-multiply job: K activation vectors against one ROW×COL weight block. It then drives the weight buffer reads and `weight_en` to shift weights into the array, streams activation-buffer reads, and generates the per-row skew masks and per-column output-valid strobes. It sits between the job scheduler (start/done handshake) and the weight/activation SRAMs, the skew buffers and `sys_array`.

---
 rtl/sys_array_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sys_array_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_ctrl.sv
// Sequencing controller for the weight-stationary sys_array tile: weight load, activation stream, skew/valid strobes.
// Optional weight reuse across jobs is enabled by defining SYS_CTRL_WEIGHT_REUSE_EN.
module sys_array_ctrl #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int ARR_LAT = ROW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  num_vec,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic              reuse_w,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              weight_en,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ROW-1:0]    row_valid,
    output logic [COL-1:0]    col_out_valid
);
    localparam int DRAIN_LEN = ARR_LAT + COL - 1;
    localparam int PH_MAX    = (ROW + 1 > DRAIN_LEN) ? ROW + 1 : DRAIN_LEN;
    localparam int PH_W      = $clog2(PH_MAX + 1);
    localparam int DLY_LEN   = (ROW > DRAIN_LEN) ? ROW : DRAIN_LEN;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [LEN_W-1:0]   vec_q, vec_d;
    logic [LEN_W-1:0]   num_vec_q, num_vec_d;
    logic [ADDR_W-1:0]  w_base_q, w_base_d;
    logic [ADDR_W-1:0]  a_base_q, a_base_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_len_q, err_len_d;
    logic               w_rd_en_q, w_rd_en_d;
    logic [ADDR_W-1:0]  w_rd_addr_q, w_rd_addr_d;
    logic               weight_en_q, weight_en_d;
    logic               a_rd_en_q, a_rd_en_d;
    logic [ADDR_W-1:0]  a_rd_addr_q, a_rd_addr_d;
    logic [DLY_LEN-1:0] dly_q, dly_d;
    logic               reuse_ok;

`ifdef SYS_CTRL_WEIGHT_REUSE_EN
    logic wv_q, wv_d;
    assign reuse_ok = reuse_w && wv_q;
`else
    logic unused_reuse_w;
    assign unused_reuse_w = reuse_w;
    assign reuse_ok       = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d   = state_q;
        ph_d      = ph_q;
        vec_d     = vec_q;
        num_vec_d = num_vec_q;
        w_base_d  = w_base_q;
        a_base_d  = a_base_q;
        err_len_d = 1'b0;
`ifdef SYS_CTRL_WEIGHT_REUSE_EN
        wv_d      = wv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_vec != '0) begin
                        num_vec_d = num_vec;
                        w_base_d  = w_base;
                        a_base_d  = a_base;
                        ph_d      = '0;
                        vec_d     = '0;
                        state_d   = reuse_ok ? S_STREAM : S_LOAD_W;
                    end else begin
                        err_len_d = 1'b1;
`ifdef SYS_CTRL_WEIGHT_REUSE_EN
                        wv_d      = 1'b0;
`endif
                    end
                end
            end
            S_LOAD_W: begin
                // Phase ROW is the flush cycle where the last read shifts into the array.
                if (ph_q == PH_W'(ROW)) begin
                    state_d = S_STREAM;
                    vec_d   = '0;
`ifdef SYS_CTRL_WEIGHT_REUSE_EN
                    wv_d    = 1'b1;
`endif
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_STREAM: begin
                if (vec_q == num_vec_q - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                    ph_d    = '0;
                end else begin
                    vec_d = vec_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if (ph_q == PH_W'(DRAIN_LEN - 1)) state_d = S_DONE;
                else                              ph_d    = ph_q + PH_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the upcoming state so that every port comes straight from a flop.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        w_rd_en_d   = (state_d == S_LOAD_W) && (ph_d < PH_W'(ROW));
        w_rd_addr_d = w_rd_en_d ? w_base_d + ADDR_W'(ROW - 1) - ADDR_W'(ph_d) : '0;
        weight_en_d = w_rd_en_q;
        a_rd_en_d   = (state_d == S_STREAM);
        a_rd_addr_d = a_rd_en_d ? a_base_d + ADDR_W'(vec_d) : '0;
        dly_d       = {dly_q[DLY_LEN-2:0], a_rd_en_q};
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            vec_q       <= '0;
            num_vec_q   <= '0;
            w_base_q    <= '0;
            a_base_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            weight_en_q <= 1'b0;
            a_rd_en_q   <= 1'b0;
            a_rd_addr_q <= '0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            vec_q       <= vec_d;
            num_vec_q   <= num_vec_d;
            w_base_q    <= w_base_d;
            a_base_q    <= a_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_len_q   <= err_len_d;
            w_rd_en_q   <= w_rd_en_d;
            w_rd_addr_q <= w_rd_addr_d;
            weight_en_q <= weight_en_d;
            a_rd_en_q   <= a_rd_en_d;
            a_rd_addr_q <= a_rd_addr_d;
            dly_q       <= dly_d;
        end
    end

`ifdef SYS_CTRL_WEIGHT_REUSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wv_q <= 1'b0;
        else     wv_q <= wv_d;
    end
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_len       = err_len_q;
    assign w_rd_en       = w_rd_en_q;
    assign w_rd_addr     = w_rd_addr_q;
    assign weight_en     = weight_en_q;
    assign a_rd_en       = a_rd_en_q;
    assign a_rd_addr     = a_rd_addr_q;
    assign row_valid     = dly_q[ROW-1:0];
    assign col_out_valid = dly_q[ARR_LAT-1 +: COL];
endmodule

// File: tb/tb_sys_array_ctrl.sv
// Scoreboard bench for sys_array_ctrl: a job-level model predicts per-cycle strobes and queued read addresses;
// a negedge monitor compares. Reuse expectations follow SYS_CTRL_WEIGHT_REUSE_EN when defined.
module tb_sys_array_ctrl;
    localparam int ROW = 4, COL = 4, ARR_LAT = 5, ADDR_W = 10, LEN_W = 10;
    localparam int DRAIN_LEN = ARR_LAT + COL - 1;
    localparam int NCYC = 8192;
    localparam int INF  = 1 << 30;
    localparam int AMOD = 1 << ADDR_W;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, reuse_w = 1'b0;
    logic [LEN_W-1:0]  num_vec = '0;
    logic [ADDR_W-1:0] w_base = '0, a_base = '0;
    logic              busy, done, err_len, w_rd_en, weight_en, a_rd_en;
    logic [ADDR_W-1:0] w_rd_addr, a_rd_addr;
    logic [ROW-1:0]    row_valid;
    logic [COL-1:0]    col_out_valid;

    sys_array_ctrl #(.ROW(ROW), .COL(COL), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ARR_LAT(ARR_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .w_base(w_base), .a_base(a_base),
        .reuse_w(reuse_w), .busy(busy), .done(done), .err_len(err_len), .w_rd_en(w_rd_en),
        .w_rd_addr(w_rd_addr), .weight_en(weight_en), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .row_valid(row_valid), .col_out_valid(col_out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0, n_chk = 0;
    bit exp_w[NCYC], exp_we[NCYC], exp_a[NCYC], exp_busy[NCYC], exp_done[NCYC], exp_err[NCYC];
    int wq[$], aq[$], dq[$];
    int idle_from = INF;
    int wv_from   = INF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Job-level model: a start at cycle c accepted when idle produces reads and strobes at fixed offsets.
    task automatic model_start(input int c, input int k, input int wb, input int ab, input bit ru);
        bit reuse;
        int load, a0, d;
        if (c < idle_from) return;
        if (k == 0) begin
            exp_err[c+1] = 1'b1;
            idle_from    = c + 1;
            wv_from      = INF;
            return;
        end
`ifdef SYS_CTRL_WEIGHT_REUSE_EN
        reuse = ru && (c >= wv_from);
`else
        reuse = ru && 1'b0;
`endif
        load = reuse ? 0 : ROW + 1;
        if (!reuse) begin
            for (int n = 0; n < ROW; n++) begin
                exp_w[c+1+n]  = 1'b1;
                exp_we[c+2+n] = 1'b1;
                wq.push_back((wb + ROW - 1 - n) % AMOD);
            end
            wv_from = c + ROW + 2;
        end
        a0 = c + 1 + load;
        for (int n = 0; n < k; n++) begin
            exp_a[a0+n] = 1'b1;
            aq.push_back((ab + n) % AMOD);
        end
        d = a0 + k + DRAIN_LEN;
        for (int t = c + 1; t <= d; t++) exp_busy[t] = 1'b1;
        exp_done[d] = 1'b1;
        dq.push_back(d);
        idle_from = d + 1;
    endtask

    task automatic drive(input bit st, input int k, input int wb, input int ab, input bit ru);
        @(posedge clk);
        #1;
        start   = st;
        num_vec = LEN_W'(k);
        w_base  = ADDR_W'(wb);
        a_base  = ADDR_W'(ab);
        reuse_w = ru;
        if (st) model_start(cyc, k, wb, ab, ru);
    endtask

    task automatic idle_until_free();
        int g = 0;
        while (cyc + 1 < idle_from && g < 300) begin
            drive(1'b0, 0, 0, 0, 1'b0);
            g++;
        end
        check("idle_bound", (cyc + 1 >= idle_from) ? 1 : 0, 1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, err_len, w_rd_en, weight_en, a_rd_en, row_valid, col_out_valid}, '0);
        check({name, "_addr"}, {w_rd_addr, a_rd_addr}, '0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        exp_w = '{default: 1'b0};  exp_we   = '{default: 1'b0}; exp_a   = '{default: 1'b0};
        exp_busy = '{default: 1'b0}; exp_done = '{default: 1'b0}; exp_err = '{default: 1'b0};
        wq.delete(); aq.delete(); dq.delete();
        wv_from = INF;
        #1;
        check_all_zero("rst_outputs");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        idle_from = cyc;
    endtask

    logic [ROW-1:0] rv_exp;
    logic [COL-1:0] cv_exp;
    always @(negedge clk) begin
        if (cyc > 0 && cyc < NCYC) begin
            check("ctrl", {busy, done, err_len, w_rd_en, weight_en, a_rd_en},
                  {exp_busy[cyc], exp_done[cyc], exp_err[cyc], exp_w[cyc], exp_we[cyc], exp_a[cyc]});
            for (int i = 0; i < ROW; i++) rv_exp[i] = (cyc - 1 - i >= 0) && exp_a[cyc-1-i];
            for (int j = 0; j < COL; j++) cv_exp[j] = (cyc - ARR_LAT - j >= 0) && exp_a[cyc-ARR_LAT-j];
            check("row_valid", row_valid, rv_exp);
            check("col_out_valid", col_out_valid, cv_exp);
            if (w_rd_en) begin
                if (wq.size() == 0) check("w_rd_unexpected", wq.size(), 1);
                else                check("w_rd_addr", w_rd_addr, wq.pop_front());
            end
            if (a_rd_en) begin
                if (aq.size() == 0) check("a_rd_unexpected", aq.size(), 1);
                else                check("a_rd_addr", a_rd_addr, aq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0) check("done_unexpected", dq.size(), 1);
                else                check("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    initial begin
        #(NCYC * 10);
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst       = 1'b0;
        idle_from = cyc;

        // Basic job, start held through it (ignored, including the DONE cycle), then a start right after DONE.
        drive(1'b1, 3, 'h10, 'h40, 1'b0);
        repeat (17) drive(1'b1, 5, 'h200, 'h100, 1'b1);
        drive(1'b1, 2, 'h20, 'h80, 1'b0);
        idle_until_free();

        // K=0 rejection, then address wrap.
        drive(1'b1, 0, 'h55, 'h66, 1'b0);
        repeat (3) drive(1'b0, 0, 0, 0, 1'b0);
        drive(1'b1, 3, 'h10, 'h3FE, 1'b0);
        idle_until_free();

        // Load then reuse job.
        drive(1'b1, 1, 'h30, 'h50, 1'b0);
        idle_until_free();
        drive(1'b1, 2, 'h30, 'h60, 1'b1);
        idle_until_free();

        // Reset at cycle 7 of the basic job; the following reuse request must load weights again.
        drive(1'b1, 3, 'h10, 'h40, 1'b0);
        repeat (6) drive(1'b0, 0, 0, 0, 1'b0);
        apply_reset();
        drive(1'b1, 2, 'h30, 'h60, 1'b1);
        idle_until_free();

        // Randomized traffic with occasional resets.
        while (cyc < 2600) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                drive($urandom_range(0, 3) == 0,
                      ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
                      int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
                      1'($urandom_range(0, 1)));
            end
        end
        drive(1'b0, 0, 0, 0, 1'b0);
        idle_until_free();
        repeat (12) drive(1'b0, 0, 0, 0, 1'b0);
        check("w_queue_empty", wq.size(), 0);
        check("a_queue_empty", aq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
